// File: rtl/ternary_host_seq_if.sv
// Host-side bundle between the command/payload source, the ternary accelerator bus
// and the result sink.
interface ternary_host_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_in_len;
    logic [3:0]  cmd_out_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [15:0] bus_out;
    logic [7:0]  dut_out;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        busy;
    logic        err;

    modport master (
        output cmd_valid, cmd_op, cmd_in_len, cmd_out_len, wr_valid, wr_data, dut_out,
        input  cmd_ready, wr_ready, bus_out, res_valid, res_data, busy, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_in_len, cmd_out_len, wr_valid, wr_data, dut_out,
        output cmd_ready, wr_ready, bus_out, res_valid, res_data, busy, err
    );
endinterface

// File: rtl/ternary_host_seq.sv
// Command sequencer for the ternary accelerator: buffers a payload, emits a gap-free
// header/payload/terminator frame on bus_out, then captures result bytes.
//
// state | meaning
// IDLE  | waiting for a command, bus parked at 0x0000
// FILL  | collecting N payload words into the buffer
// HDR   | header word on the bus
// BURST | buffered payload words, one per cycle
// TERM  | 0x0000 terminator word
// CAPT  | latency wait then capture of result bytes
module ternary_host_seq #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int RES_LAT     = 2
) (
    input logic clk,
    input logic rst_n,
    ternary_host_seq_if.slave hif
);
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_HDR, S_BURST, S_TERM, S_CAPT} state_t;

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_MULT  = 2'd2;
    localparam logic [1:0] OP_OUT   = 2'd3;
    localparam logic [4:0] MAX_IN   = 5'(MAX_IN_LEN);
    localparam logic [3:0] MAX_OUT  = 4'(MAX_OUT_LEN);
    localparam logic [2:0] LAT_LOAD = 3'(RES_LAT - 1);

    state_t      state_q, state_d;
    logic [15:0] bus_q, bus_d;
    logic        err_q, err_d;
    logic        accept;

    logic [1:0]  op_q;
    logic [4:0]  in_q;
    logic [3:0]  out_q;
    logic [4:0]  n_words_q;
    logic [5:0]  n_cap_q;
    logic [4:0]  wp_q, rp_q;
    logic        zero_q;
    logic [2:0]  lat_q;
    logic [5:0]  cap_left_q;
    logic        res_valid_q;
    logic [7:0]  res_data_q;
    logic [15:0] buf_mem [16];

    logic        cmd_ok;
    logic [7:0]  prod;
    logic [4:0]  n_words_cmd;
    logic [5:0]  n_cap_cmd;
    logic        wr_fire, last_word, mult_zero, cap_fire;
    logic [15:0] hdr_word;

    assign cmd_ok = (hif.cmd_op != 2'd0)
                 && (hif.cmd_in_len != 5'd0) && (hif.cmd_in_len <= MAX_IN)
                 && (hif.cmd_out_len != 4'd0) && (hif.cmd_out_len <= MAX_OUT)
                 && !((hif.cmd_op == OP_MULT) && hif.cmd_in_len[0]);

    assign prod = 8'(hif.cmd_in_len) * 8'(hif.cmd_out_len);

    always_comb begin
        n_words_cmd = 5'd0;
        n_cap_cmd   = 6'd0;
        case (hif.cmd_op)
            OP_LOAD: n_words_cmd = 5'((prod + 8'd7) >> 3);
            OP_MULT: begin
                n_words_cmd = {1'b0, hif.cmd_in_len[4:1]};
                n_cap_cmd   = {2'b00, hif.cmd_out_len};
            end
            OP_OUT:  n_cap_cmd = 6'((prod + 8'd3) >> 2);
            default: ;
        endcase
    end

    assign wr_fire   = (state_q == S_FILL) && hif.wr_valid;
    assign last_word = wr_fire && ((wp_q + 5'd1) == n_words_q);
    // A zero word would end MULT early inside the accelerator, so such frames are dropped.
    assign mult_zero = (op_q == OP_MULT) && (zero_q || (hif.wr_data == 16'h0000));
    assign cap_fire  = (state_q == S_CAPT) && (lat_q == 3'd0);

    always_comb begin
        hdr_word = 16'hB000;
        case (op_q)
            OP_LOAD: hdr_word = {4'hA, 4'(in_q - 5'd1), 3'(out_q - 4'd1), 5'b00000};
            OP_MULT: hdr_word = 16'hF000;
            default: hdr_word = 16'hB000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        bus_d   = 16'h0000;
        err_d   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hif.cmd_valid) begin
                    if (cmd_ok) begin
                        accept = 1'b1;
                        if (hif.cmd_op == OP_OUT) begin
                            state_d = S_HDR;
                            bus_d   = 16'hB000;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (last_word) begin
                    if (mult_zero) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HDR;
                        bus_d   = hdr_word;
                    end
                end
            end
            S_HDR: begin
                if (op_q == OP_OUT) begin
                    state_d = S_CAPT;
                end else begin
                    state_d = S_BURST;
                    bus_d   = buf_mem[0];
                end
            end
            S_BURST: begin
                if (rp_q == n_words_q) begin
                    state_d = S_TERM;
                end else begin
                    bus_d = buf_mem[rp_q[3:0]];
                end
            end
            S_TERM: state_d = (op_q == OP_MULT) ? S_CAPT : S_IDLE;
            S_CAPT: begin
                if (cap_fire && (cap_left_q == 6'd1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bus_q       <= 16'h0000;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            op_q        <= 2'd0;
            in_q        <= 5'd0;
            out_q       <= 4'd0;
            n_words_q   <= 5'd0;
            n_cap_q     <= 6'd0;
            wp_q        <= 5'd0;
            rp_q        <= 5'd0;
            zero_q      <= 1'b0;
            lat_q       <= 3'd0;
            cap_left_q  <= 6'd0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            err_q       <= err_d;
            res_valid_q <= cap_fire;
            if (cap_fire) begin
                res_data_q <= hif.dut_out;
            end
            if (accept) begin
                op_q      <= hif.cmd_op;
                in_q      <= hif.cmd_in_len;
                out_q     <= hif.cmd_out_len;
                n_words_q <= n_words_cmd;
                n_cap_q   <= n_cap_cmd;
                wp_q      <= 5'd0;
                zero_q    <= 1'b0;
            end else if (wr_fire) begin
                wp_q <= wp_q + 5'd1;
                if (hif.wr_data == 16'h0000) begin
                    zero_q <= 1'b1;
                end
            end
            if (state_q == S_HDR) begin
                rp_q <= 5'd1;
            end else if ((state_q == S_BURST) && (rp_q != n_words_q)) begin
                rp_q <= rp_q + 5'd1;
            end
            // Latency is counted from the reference cycle: TERM for MULT, HDR for OUT.
            if (((state_q == S_TERM) && (op_q == OP_MULT)) ||
                ((state_q == S_HDR) && (op_q == OP_OUT))) begin
                lat_q      <= LAT_LOAD;
                cap_left_q <= n_cap_q;
            end else if (state_q == S_CAPT) begin
                if (lat_q != 3'd0) begin
                    lat_q <= lat_q - 3'd1;
                end else begin
                    cap_left_q <= cap_left_q - 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            buf_mem[wp_q[3:0]] <= hif.wr_data;
        end
    end

    assign hif.cmd_ready = (state_q == S_IDLE);
    assign hif.wr_ready  = (state_q == S_FILL);
    assign hif.busy      = (state_q != S_IDLE);
    assign hif.bus_out   = bus_q;
    assign hif.err       = err_q;
    assign hif.res_valid = res_valid_q;
    assign hif.res_data  = res_data_q;
endmodule

// File: tb/tb_ternary_host_seq.sv
// Randomized scoreboard bench for ternary_host_seq: the driver predicts frames, error
// pulses and capture windows; a negedge monitor checks whatever the DUT presents.
module tb_ternary_host_seq;
    localparam int RES_LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ternary_host_seq_if hif();

    ternary_host_seq #(.MAX_IN_LEN(16), .MAX_OUT_LEN(8), .RES_LAT(RES_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif.slave)
    );

    typedef struct {logic [15:0] w; bit last; int cap_n; bit ref_hdr;} bus_e_t;
    typedef struct {int cyc; logic [7:0] d;} res_e_t;

    bus_e_t exp_bus[$];
    res_e_t exp_res[$];
    int     exp_err[$];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int exp_hdr_cyc = 0;
    int hdr_cyc = 0;
    int ref_c = 0;
    bit in_frame = 0;
    bit run_mon = 0;
    logic [7:0] salt;
    bus_e_t me;
    res_e_t mr;

    // dut_out is a known function of the cycle number, so each captured byte reveals when it was sampled.
    always @(posedge clk) cyc <= cyc + 1;
    assign hif.dut_out = 8'(cyc * 37) + salt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    always @(negedge clk) begin
        if (run_mon) begin
            chk("busy_vs_cmd_ready", hif.busy, !hif.cmd_ready);
            if (!in_frame) begin
                if (hif.bus_out !== 16'h0000) begin
                    if (exp_bus.size() == 0) begin
                        fail_now("bus_unexpected", hif.bus_out);
                    end else begin
                        me = exp_bus.pop_front();
                        chk("bus_header", hif.bus_out, me.w);
                        chk("header_cycle", cyc, exp_hdr_cyc);
                        hdr_cyc  = cyc;
                        in_frame = 1;
                    end
                end
            end else begin
                if (exp_bus.size() == 0) begin
                    fail_now("bus_overrun", hif.bus_out);
                    in_frame = 0;
                end else begin
                    me = exp_bus.pop_front();
                    chk("bus_word", hif.bus_out, me.w);
                    if (me.last) begin
                        in_frame = 0;
                        ref_c = me.ref_hdr ? hdr_cyc : cyc;
                        for (int k = 0; k < me.cap_n; k++) begin
                            mr.cyc = ref_c + RES_LAT + k + 1;
                            mr.d   = 8'((ref_c + RES_LAT + k) * 37) + salt;
                            exp_res.push_back(mr);
                        end
                    end
                end
            end
            if (hif.res_valid) begin
                if (exp_res.size() == 0) begin
                    fail_now("res_unexpected", hif.res_data);
                end else begin
                    mr = exp_res.pop_front();
                    chk("res_cycle", cyc, mr.cyc);
                    chk("res_data", hif.res_data, mr.d);
                end
            end
            if (hif.err) begin
                if (exp_err.size() == 0) fail_now("err_unexpected", 1);
                else chk("err_cycle", cyc, exp_err.pop_front());
            end
        end
    end

    task automatic wait_ready(input int limit, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            if (hif.cmd_ready) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) fail_now(name, 0);
    endtask

    task automatic do_cmd(input int op, input int in_len, input int out_len,
                          input int zero_idx, input bit seq_words, input bit abort);
        bit ok, zero;
        int n, ncap;
        logic [15:0] w;
        logic [15:0] words[$];
        bus_e_t e;

        ok = (op != 0) && (in_len >= 1) && (in_len <= 16) && (out_len >= 1) && (out_len <= 8)
             && !(op == 2 && (in_len % 2) == 1);
        n    = (op == 1) ? (in_len * out_len + 7) / 8 : (op == 2) ? in_len / 2 : 0;
        ncap = (op == 2) ? out_len : (op == 3) ? (in_len * out_len + 3) / 4 : 0;
        zero = 0;
        for (int i = 0; i < n; i++) begin
            w = seq_words ? 16'(i + 1) : 16'($urandom);
            if (op == 2 && w == 16'h0000) w = 16'h0001;
            if (i == zero_idx) w = 16'h0000;
            if (op == 2 && w == 16'h0000) zero = 1;
            words.push_back(w);
        end

        if (ok && !zero) begin
            e.last = 0; e.cap_n = 0; e.ref_hdr = 0;
            e.w = (op == 1) ? 16'(16'hA000 + (in_len - 1) * 256 + (out_len - 1) * 32)
                : (op == 2) ? 16'hF000 : 16'hB000;
            exp_bus.push_back(e);
            foreach (words[i]) begin
                e.w = words[i];
                exp_bus.push_back(e);
            end
            e.w = 16'h0000; e.last = 1; e.cap_n = ncap; e.ref_hdr = (op == 3);
            exp_bus.push_back(e);
        end

        wait_ready(300, "timeout_cmd_ready");
        hif.cmd_valid   = 1'b1;
        hif.cmd_op      = 2'(op);
        hif.cmd_in_len  = 5'(in_len);
        hif.cmd_out_len = 4'(out_len);
        if (!ok) exp_err.push_back(cyc + 1);
        if (ok && op == 3) exp_hdr_cyc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        hif.cmd_valid   = 1'b0;
        hif.cmd_op      = 2'($urandom);
        hif.cmd_in_len  = 5'($urandom);
        hif.cmd_out_len = 4'($urandom);
        if (!ok) begin
            chk("reject_wr_ready", hif.wr_ready, 0);
            chk("reject_cmd_ready", hif.cmd_ready, 1);
            return;
        end

        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            chk("fill_wr_ready", hif.wr_ready, 1);
            hif.wr_valid = 1'b1;
            hif.wr_data  = words[i];
            if (i == n - 1) begin
                if (zero) exp_err.push_back(cyc + 1);
                else exp_hdr_cyc = cyc + 1;
            end
            @(posedge clk);
            @(negedge clk);
            hif.wr_valid = 1'b0;
            hif.wr_data  = 16'($urandom);
        end

        if (abort) begin
            repeat (6) @(negedge clk);
            #1;
            rst_n = 1'b0;
            exp_res.delete();
            exp_bus.delete();
            in_frame = 0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("abort_bus_out", hif.bus_out, 16'h0000);
            chk("abort_res_valid", hif.res_valid, 0);
            chk("abort_busy", hif.busy, 0);
            #1;
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            chk("abort_quiet_res", hif.res_valid, 0);
            return;
        end

        @(negedge clk);
        wait_ready(300, "timeout_frame_done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int op, in_len, out_len, zi;
        salt            = 8'($urandom);
        hif.cmd_valid   = 1'b0;
        hif.cmd_op      = 2'd0;
        hif.cmd_in_len  = 5'd0;
        hif.cmd_out_len = 4'd0;
        hif.wr_valid    = 1'b0;
        hif.wr_data     = 16'h0000;
        rst_n           = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_bus_out", hif.bus_out, 16'h0000);
        chk("reset_res_valid", hif.res_valid, 0);
        chk("reset_res_data", hif.res_data, 8'h00);
        chk("reset_err", hif.err, 0);
        chk("reset_busy", hif.busy, 0);
        chk("reset_cmd_ready", hif.cmd_ready, 1);
        chk("reset_wr_ready", hif.wr_ready, 0);
        rst_n   = 1'b1;
        run_mon = 1;
        @(negedge clk);

        do_cmd(1, 16, 8, -1, 1, 0);
        do_cmd(2, 4, 2, -1, 0, 0);
        do_cmd(2, 4, 2, 0, 0, 0);
        do_cmd(0, 4, 2, -1, 0, 0);
        do_cmd(2, 3, 2, -1, 0, 0);
        do_cmd(1, 4, 9, -1, 0, 0);
        do_cmd(3, 8, 4, -1, 0, 0);

        for (int it = 0; it < 30; it++) begin
            op      = $urandom_range(0, 3);
            in_len  = $urandom_range(0, 17);
            out_len = $urandom_range(0, 9);
            zi      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
            do_cmd(op, in_len, out_len, zi, 0, 0);
        end

        do_cmd(3, 16, 8, -1, 0, 1);
        do_cmd(2, 6, 3, -1, 0, 0);
        do_cmd(1, 3, 5, -1, 0, 0);

        repeat (5) @(negedge clk);
        chk("bus_queue_empty", exp_bus.size(), 0);
        chk("res_queue_empty", exp_res.size(), 0);
        chk("err_queue_empty", exp_err.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
